// File: rtl/ospi_master_ctrl.sv
// Octal-SPI (x8 SDR) master sequencer.
//
// One transaction = CMD slot, WIDTH/8 ADDR slots, optional DUMMY slots (reads
// only), len+1 DATA slots, then a single DONE cycle with CS released.
// Every slot is two clk cycles: OSPI_CLK low in cycle 1, high in cycle 2.
// OSPI_DQ_O is reloaded only on the edge that starts a slot.
//
// Write data handshake: the byte on wdata is latched on the edge that starts
// each write DATA slot, and wdata_req is high during that slot's first cycle.
// The host should present the next byte before the next slot starts, i.e.
// advance wdata in response to wdata_req (first byte ready at start).
//
// Read data: OSPI_DQ_I is sampled on the edge that ends cycle 2 of each read
// DATA slot; rdata/rdata_valid present it during the following cycle.
//
//   state | meaning
//   ------+-------------------------------------------------------
//   IDLE  | CS high, ready=1, waiting for start
//   CMD   | one slot driving the command byte
//   ADDR  | WIDTH/8 slots driving the address, MSB byte first
//   DUMMY | dummy slots for reads, bus released
//   DATA  | len+1 slots, write drives wdata / read samples DQ_I
//   DONE  | one cycle, CS high, done pulse
module ospi_master_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic             rw,
  input  logic [7:0]       cmd,
  input  logic [WIDTH-1:0] addr,
  input  logic [3:0]       dummy,
  input  logic [7:0]       len,
  input  logic [7:0]       wdata,
  output logic             wdata_req,
  output logic [7:0]       rdata,
  output logic             rdata_valid,
  output logic             done,
  output logic             OSPI_CLK,
  output logic             OSPI_CS,
  output logic [7:0]       OSPI_DQ_O,
  output logic             OSPI_DQ_OE,
  input  logic [7:0]       OSPI_DQ_I
);

  localparam int NAB = WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    DUMMY = 3'd3,
    DATA  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             phase_q, phase_d;
  // Slots left in the current state minus one; 9 bits covers 256 data slots.
  logic [8:0]       cnt_q, cnt_d;
  logic             rw_q, rw_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [3:0]       dummy_q, dummy_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       dq_q, dq_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rv_q, rv_d;
  logic             wreq_q, wreq_d;
  logic             enter_data;
  logic             busy;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      dummy_q <= '0;
      len_q   <= '0;
      dq_q    <= '0;
      rdata_q <= '0;
      rv_q    <= 1'b0;
      wreq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      dummy_q <= dummy_d;
      len_q   <= len_d;
      dq_q    <= dq_d;
      rdata_q <= rdata_d;
      rv_q    <= rv_d;
      wreq_q  <= wreq_d;
    end
  end

  // Next-state logic: slot sequencing, byte loading and read sampling.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    dummy_d    = dummy_q;
    len_d      = len_q;
    dq_d       = dq_q;
    rdata_d    = rdata_q;
    rv_d       = 1'b0;
    wreq_d     = 1'b0;
    enter_data = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          rw_d    = rw;
          addr_d  = addr;
          dummy_d = dummy;
          len_d   = len;
          dq_d    = cmd;
          cnt_d   = '0;
          phase_d = 1'b0;
          state_d = CMD;
        end
      end
      CMD, ADDR, DUMMY, DATA: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (state_q == DATA && rw_q) begin
            rdata_d = OSPI_DQ_I;
            rv_d    = 1'b1;
          end
          if (cnt_q != 9'd0) begin
            cnt_d = cnt_q - 9'd1;
            if (state_q == ADDR) begin
              dq_d   = addr_q[WIDTH-1 -: 8];
              addr_d = addr_q << 8;
            end else if (state_q == DATA && !rw_q) begin
              dq_d   = wdata;
              wreq_d = 1'b1;
            end
          end else begin
            case (state_q)
              CMD: begin
                state_d = ADDR;
                cnt_d   = 9'(NAB - 1);
                dq_d    = addr_q[WIDTH-1 -: 8];
                addr_d  = addr_q << 8;
              end
              ADDR: begin
                if (rw_q && dummy_q != 4'd0) begin
                  state_d = DUMMY;
                  cnt_d   = {5'd0, dummy_q} - 9'd1;
                end else begin
                  enter_data = 1'b1;
                end
              end
              DUMMY:   enter_data = 1'b1;
              default: state_d = DONE;
            endcase
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (enter_data) begin
      state_d = DATA;
      cnt_d   = {1'b0, len_q};
      if (!rw_q) begin
        dq_d   = wdata;
        wreq_d = 1'b1;
      end
    end
  end

  assign busy        = (state_q == CMD) || (state_q == ADDR) ||
                       (state_q == DUMMY) || (state_q == DATA);
  assign ready       = (state_q == IDLE);
  assign done        = (state_q == DONE);
  assign OSPI_CS     = ~busy;
  assign OSPI_CLK    = busy & phase_q;
  assign OSPI_DQ_OE  = (state_q == CMD) || (state_q == ADDR) ||
                       (state_q == DATA && !rw_q);
  assign OSPI_DQ_O   = dq_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rv_q;
  assign wdata_req   = wreq_q;

endmodule

// File: doc/ospi_master_ctrl.md
OSPI_MASTER_CTRL -- requirements
Module: ospi_master_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, address width in bits; legal values are multiples of 8 from 8 to 32.
REQ-002 SHALL have port clk  in  1  system clock; all logic on rising edge; one clock domain.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port start  in  1  transaction request; accepted only when ready=1.
REQ-005 SHALL have port ready  out  1  high when idle and able to accept start.
REQ-006 SHALL have port rw  in  1  1=read, 0=write; captured on start.
REQ-007 SHALL have port cmd  in  8  command byte; captured on start.
REQ-008 SHALL have port addr  in  WIDTH  address; captured on start; sent MSB byte first.
REQ-009 SHALL have port dummy  in  4  read dummy slots 0..15; captured on start.
REQ-010 SHALL have port len  in  8  data byte count minus 1 (0 -> 1 byte, 255 -> 256 bytes); captured on start.
REQ-011 SHALL have port wdata  in  8  write data byte.
REQ-012 SHALL have port wdata_req  out  1  one-cycle pulse when wdata is latched.
REQ-013 SHALL have port rdata  out  8  read data byte.
REQ-014 SHALL have port rdata_valid  out  1  one-cycle pulse qualifying rdata.
REQ-015 SHALL have port done  out  1  one-cycle pulse at end of transaction.
REQ-016 SHALL have port OSPI_CLK  out  1  flash serial clock, idle low.
REQ-017 SHALL have port OSPI_CS  out  1  flash chip select, active low.
REQ-018 SHALL have ports OSPI_DQ_O  out  8, OSPI_DQ_OE  out  1, OSPI_DQ_I  in  8  octal data bus, out, enable, in.

Function
REQ-019 SHALL implement states IDLE, CMD, ADDR, DUMMY, DATA, DONE.
REQ-020 SHALL transfer one byte per slot on all 8 DQ lines, SDR; a slot is 2 clk cycles: OSPI_CLK=0 in cycle 1, 1 in cycle 2.
REQ-021 SHALL update OSPI_DQ_O only at the start of a slot, held for the whole slot.
REQ-022 SHALL register OSPI_DQ_I at the clk edge ending a read DATA slot's cycle 2.
REQ-023 SHALL, on start=1 with ready=1, capture all request fields, drive ready=0, and enter CMD with OSPI_CS=0 in the next cycle.
REQ-024 SHALL ignore start when ready=0.
REQ-025 SHALL spend 1 slot in CMD (DQ_O=cmd, OE=1), WIDTH/8 slots in ADDR (OE=1).
REQ-026 SHALL spend dummy slots in DUMMY for reads, OE=0; skip DUMMY when dummy=0 or rw=0.
REQ-027 SHALL spend len+1 slots in DATA; write: OE=1, wdata latched and wdata_req pulsed in cycle 1 of each slot; read: OE=0.
REQ-028 SHALL pulse rdata_valid with the sampled byte in the cycle after each read sample.
REQ-029 SHALL, after the last DATA slot, enter DONE for 1 cycle: OSPI_CS=1, OSPI_CLK=0, OE=0, done=1; then IDLE with ready=1.
REQ-030 SHALL keep OSPI_CLK=0 and OSPI_CS=1 in IDLE and DONE; OSPI_CS high time between transactions is at least 2 clk cycles.
REQ-031 SHALL count slots with a counter wide enough for 256 data bytes without wrap-around.

Reset
REQ-032 SHALL, when reset=1 in any state, enter IDLE in the next cycle: ready=1, OSPI_CS=1, OSPI_CLK=0, OSPI_DQ_OE=0, OSPI_DQ_O=0, rdata=0, wdata_req=0, rdata_valid=0, done=0.
REQ-033 SHALL give reset priority over start in the same cycle; a transaction aborted by reset produces no done pulse.

Verification
REQ-034 Read: WIDTH=8, cmd=0x03, addr=0x5A, dummy=2, len=1, model returns 0xA5,0x3C -> CS low 12 cycles; DQ_O 0x03 then 0x5A; rdata_valid twice with 0xA5, 0x3C; done 1 cycle after CS rises.
REQ-035 Write: cmd=0x02, addr=0x10, len=0, wdata=0x77, dummy=5 -> CS low 6 cycles, no DUMMY, DQ_O 0x02,0x10,0x77, one wdata_req, done once.
REQ-036 WIDTH=24, read, cmd=0x0B, addr=0x123456, dummy=0, len=0 -> address slots 0x12,0x34,0x56; CS low 10 cycles.
REQ-037 len=255 write -> 256 wdata_req pulses, CS low 2*(2+256)=516 cycles, no counter wrap.
REQ-038 start pulsed mid-transaction -> ignored; reset asserted in DATA -> CS=1, OE=0, ready=1 next cycle, no done.
